tinyalu_arbiter: RTL and testbench
==================================

Name: tinyalu_arbiter

Overview:
Round-robin arbiter and sequencer that shares one TinyALU among NUM_REQ requesters. It selects one pending request and drives the ALU start/op/A/B handshake until done. It returns the 16-bit result to the winning requester, then enforces a start-low gap before the next command. It sits between the stimulus/command sources and the single TinyALU instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 16, max cycles in ISSUE waiting for done (used only with the optional feature)

Ports:
clk  input  1  clock; all logic on posedge
reset_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request level
req_op  input  3*NUM_REQ  opcode, requester k at bits [3k+2:3k]; 000 no_op, 001 add, 010 and, 011 xor, 100 mul
req_a  input  8*NUM_REQ  operand A, requester k at bits [8k+7:8k]
req_b  input  8*NUM_REQ  operand B, same packing as req_a
alu_start  output  1  TinyALU start
alu_op  output  3  TinyALU op
alu_a  output  8  TinyALU A
alu_b  output  8  TinyALU B
alu_done  input  1  TinyALU done
alu_result  input  16  TinyALU result
rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse
rsp_result  output  16  result, valid with rsp_valid
rsp_err  output  1  error flag, valid with rsp_valid
grant_id  output  clog2(NUM_REQ)  index of current/last granted requester
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all outputs 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
  - Applies immediately mid-operation; the ALU is not waited on.
- Requester rules:
  - Hold req high with stable op/A/B until its rsp_valid pulse.
  - req sampled high in IDLE after rsp_valid counts as a new request.
- States: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE:
  - Scan req starting at pointer+1 modulo NUM_REQ; first set bit wins.
  - On a win: latch op/A/B into alu_op/alu_a/alu_b, set grant_id, update pointer to the winner.
  - Legal op (000..100): go to ISSUE with alu_start=1 on the next cycle.
  - Illegal op (101..111): ALU not touched; go to RESP with rsp_err=1, rsp_result=0.
- ISSUE, add/and/xor/mul:
  - Hold alu_start=1 with operands stable.
  - At the posedge where alu_done=1: capture alu_result, drop alu_start, go to RESP.
- ISSUE, no_op: exactly one cycle of alu_start=1, then RESP with rsp_result=0 and rsp_err=0. alu_done is ignored.
- RESP (one cycle):
  - alu_start=0.
  - rsp_valid[grant_id]=1; rsp_result and rsp_err valid.
  - Next state IDLE.
  - RESP followed by one IDLE cycle guarantees at least 2 cycles of start low between commands.
- Minimum latency, req high to rsp_valid: 3 cycles for a single-cycle op (IDLE sample, ISSUE, RESP). A multi-cycle op adds its done latency.
- Outside RESP: rsp_valid=0; rsp_result and rsp_err hold their last values.
- rsp_valid is never multi-hot.
- A requester's own req changing during ISSUE has no effect; operands are already latched.
- alu_done seen outside ISSUE is ignored.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.

Optional Feature:
Macro TINYALU_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle.
  - If it reaches TIMEOUT_CYCLES without alu_done: drop alu_start, go to RESP with rsp_err=1, rsp_result=16'hFFFF.
- Undefined: no counter; ISSUE waits for alu_done indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- Single add: req[0]=1, op=001, A=8'h12, B=8'h34, ALU done after 1 cycle -> rsp_valid=4'b0001 three cycles after req, rsp_result=16'h0046, rsp_err=0, alu_start low for at least 2 cycles afterwards.
- Round robin: req=4'b1111 held, each re-asserted after its response -> grant order 0,1,2,3,0; no rsp_valid ever multi-hot.
- Mul latency: req[2], op=100, A=8'hFF, B=8'hFF, done after 3 cycles -> rsp_valid[2] with rsp_result=16'hFE01; alu_a/alu_b/alu_op stable throughout ISSUE.
- no_op and illegal: req[1] op=000 -> one start cycle, rsp_result=0, rsp_err=0; req[3] op=3'b110 -> alu_start never asserted, rsp_valid[3] with rsp_err=1.
- Reset mid-operation: reset_n low during ISSUE of a mul -> alu_start, busy and rsp_valid are 0 immediately; after release with req=4'b1010, requester 1 wins first.
- With TINYALU_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, alu_done held 0 -> rsp_err=1, rsp_result=16'hFFFF 16 cycles after ISSUE entry, then arbiter returns to IDLE.

Source files
------------

// File: rtl/tinyalu_arbiter_if.sv
// Requester-side and TinyALU-side signals of the tinyalu_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface tinyalu_arbiter_if #(
  parameter int NUM_REQ = 4
);

  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [3*NUM_REQ-1:0] req_op;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;

  logic                 alu_start;
  logic [2:0]           alu_op;
  logic [7:0]           alu_a;
  logic [7:0]           alu_b;
  logic                 alu_done;
  logic [15:0]          alu_result;

  logic [NUM_REQ-1:0]   rsp_valid;
  logic [15:0]          rsp_result;
  logic                 rsp_err;
  logic [GW-1:0]        grant_id;
  logic                 busy;

  modport slave (
    input  req, req_op, req_a, req_b, alu_done, alu_result,
    output alu_start, alu_op, alu_a, alu_b,
    output rsp_valid, rsp_result, rsp_err, grant_id, busy
  );

  modport master (
    output req, req_op, req_a, req_b, alu_done, alu_result,
    input  alu_start, alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_result, rsp_err, grant_id, busy
  );

endinterface

// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter/sequencer sharing one TinyALU among NUM_REQ requesters.
// Optional ISSUE watchdog enabled by defining TINYALU_ARB_TIMEOUT_EN.
module tinyalu_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  tinyalu_arbiter_if.slave bus
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic               alu_start_q, alu_start_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic [7:0]         alu_a_q, alu_a_d;
  logic [7:0]         alu_b_q, alu_b_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_result_q, rsp_result_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  logic               win_found_s;
  logic [GW-1:0]      win_id_s;
  logic [GW-1:0]      scan_idx_s;
  logic [2:0]         win_op_s;
  logic [7:0]         win_a_s;
  logic [7:0]         win_b_s;

`ifdef TINYALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]      tmo_cnt_q, tmo_cnt_d;
`endif

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin scan: walking far-to-near lets the requester nearest ptr+1 overwrite the others.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    scan_idx_s  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      scan_idx_s  = GW'((int'(ptr_q) + i) % NUM_REQ);
      win_found_s = win_found_s | bus.req[scan_idx_s];
      win_id_s    = bus.req[scan_idx_s] ? scan_idx_s : win_id_s;
    end
  end

  // Operand select for the scan winner.
  always_comb begin
    win_op_s = bus.req_op[3*int'(win_id_s) +: 3];
    win_a_s  = bus.req_a[8*int'(win_id_s) +: 8];
    win_b_s  = bus.req_b[8*int'(win_id_s) +: 8];
  end

  // Next-state and next-output logic; every output leaves a register.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    alu_start_d  = alu_start_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
`ifdef TINYALU_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          ptr_d    = win_id_s;
          grant_d  = win_id_s;
          alu_op_d = win_op_s;
          alu_a_d  = win_a_s;
          alu_b_d  = win_b_s;
          if (win_op_s <= 3'd4) begin
            state_d     = ISSUE;
            alu_start_d = 1'b1;
`ifdef TINYALU_ARB_TIMEOUT_EN
            tmo_cnt_d   = '0;
`endif
          end else begin
            // Illegal opcode: answer with an error without touching the ALU.
            state_d      = RESP;
            alu_start_d  = 1'b0;
            rsp_valid_d  = onehot(win_id_s);
            rsp_result_d = 16'h0000;
            rsp_err_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (alu_op_q == 3'd0) begin
          state_d      = RESP;
          alu_start_d  = 1'b0;
          rsp_valid_d  = onehot(grant_q);
          rsp_result_d = 16'h0000;
          rsp_err_d    = 1'b0;
        end else if (bus.alu_done) begin
          state_d      = RESP;
          alu_start_d  = 1'b0;
          rsp_valid_d  = onehot(grant_q);
          rsp_result_d = bus.alu_result;
          rsp_err_d    = 1'b0;
        end
`ifdef TINYALU_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d      = RESP;
          alu_start_d  = 1'b0;
          rsp_valid_d  = onehot(grant_q);
          rsp_result_d = 16'hFFFF;
          rsp_err_d    = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
`else
        else begin
          state_d = ISSUE;
        end
`endif
      end
      RESP: begin
        state_d     = IDLE;
        alu_start_d = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        alu_start_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      alu_start_q  <= 1'b0;
      alu_op_q     <= 3'd0;
      alu_a_q      <= 8'd0;
      alu_b_q      <= 8'd0;
      rsp_valid_q  <= '0;
      rsp_result_q <= 16'd0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef TINYALU_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      alu_start_q  <= alu_start_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
`ifdef TINYALU_ARB_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign bus.alu_start  = alu_start_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Self-checking bench for tinyalu_arbiter: directed test-plan steps, then random traffic
// against a round-robin reference model and a behavioural TinyALU with operand-dependent latency.
module tb_tinyalu_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n;

  tinyalu_arbiter_if #(.NUM_REQ(N)) bif ();

  tinyalu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int lat_force = 0;
  int start_cnt = 0;
  int op_change_cnt = 0;
  int gap_viol = 0;
  int multi_hot = 0;
  int low_run = 2;
  int alu_cyc = 0;
  logic [18:0] op_snap = '0;

  logic [N-1:0] pend;
  logic [2:0]   rop [N];
  logic [7:0]   ra  [N];
  logic [7:0]   rb  [N];
  int           last;
  bit           from_idle;

  function automatic int lat_of(logic [7:0] a, logic [7:0] b);
    if (lat_force > 0) return lat_force;
    return 1 + ((int'(a) + int'(b)) & 3);
  endfunction

  function automatic logic [15:0] alu_calc(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // {err, result} a requester should receive for its command
  function automatic logic [16:0] exp_rsp(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    if (op == 3'd0)      return 17'd0;
    else if (op <= 3'd4) return {1'b0, alu_calc(op, a, b)};
    else                 return {1'b1, 16'h0000};
  endfunction

  // number of cycles alu_start is expected high for requester k's command
  function automatic int issue_of(int k);
    if (rop[k] == 3'd0)      return 1;
    else if (rop[k] <= 3'd4) return lat_of(ra[k], rb[k]);
    else                     return 0;
  endfunction

  function automatic int rr_pick(logic [N-1:0] p, int after);
    for (int i = 1; i <= N; i++) begin
      if (p[(after + i) % N]) return (after + i) % N;
    end
    return -1;
  endfunction

  // TinyALU model plus protocol monitors
  always @(negedge clk) begin
    if (!$onehot0(bif.rsp_valid)) multi_hot++;
    if (bif.alu_start) begin
      if (alu_cyc == 0 && low_run < 2) gap_viol++;
      if (alu_cyc > 0 && {bif.alu_op, bif.alu_a, bif.alu_b} !== op_snap) op_change_cnt++;
      op_snap = {bif.alu_op, bif.alu_a, bif.alu_b};
      low_run = 0;
      alu_cyc++;
      start_cnt++;
      if (bif.alu_op == 3'd0 || bif.alu_op > 3'd4) begin
        bif.alu_done   = 1'($urandom_range(0, 1));
        bif.alu_result = 16'($urandom);
      end else begin
        bif.alu_done   = (alu_cyc == lat_of(bif.alu_a, bif.alu_b));
        bif.alu_result = bif.alu_done ? alu_calc(bif.alu_op, bif.alu_a, bif.alu_b) : 16'($urandom);
      end
    end else begin
      alu_cyc = 0;
      if (low_run < 1000) low_run++;
      bif.alu_done   = 1'($urandom_range(0, 1));
      bif.alu_result = 16'($urandom);
    end
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bif.req = pend;
    for (int k = 0; k < N; k++) begin
      bif.req_op[3*k +: 3] = rop[k];
      bif.req_a[8*k +: 8]  = ra[k];
      bif.req_b[8*k +: 8]  = rb[k];
    end
  endtask

  task automatic set_req(int k, logic [2:0] op, logic [7:0] a, logic [7:0] b);
    rop[k]  = op;
    ra[k]   = a;
    rb[k]   = b;
    pend[k] = 1'b1;
  endtask

  task automatic rand_req(int k);
    set_req(k, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
  endtask

  // wait (bounded) for the next response and check it completely
  task automatic expect_rsp(string tag, int w, logic [16:0] ex, int n_exp, int starts_exp);
    int n;
    int s0;
    int c0;
    n  = 0;
    s0 = start_cnt;
    c0 = op_change_cnt;
    do begin
      @(negedge clk);
      n++;
    end while (bif.rsp_valid == '0 && n < 80);
    check({tag, "_lat"},    n, n_exp);
    check({tag, "_valid"},  32'(bif.rsp_valid), 32'(1) << w);
    check({tag, "_gid"},    32'(bif.grant_id), w);
    check({tag, "_res"},    32'(bif.rsp_result), 32'(ex[15:0]));
    check({tag, "_err"},    32'(bif.rsp_err), 32'(ex[16]));
    check({tag, "_startlo"}, 32'(bif.alu_start), 32'd0);
    check({tag, "_busy"},   32'(bif.busy), 32'd1);
    check({tag, "_starts"}, start_cnt - s0, starts_exp);
    check({tag, "_stable"}, op_change_cnt - c0, 32'd0);
  endtask

  initial begin
    int w;
    logic [N-1:0] p;

    reset_n = 1'b0;
    pend    = '0;
    for (int k = 0; k < N; k++) begin
      rop[k] = 3'd0;
      ra[k]  = 8'd0;
      rb[k]  = 8'd0;
    end
    drive();
    #1;
    check("rst_start", 32'(bif.alu_start), 32'd0);
    check("rst_busy",  32'(bif.busy), 32'd0);
    check("rst_valid", 32'(bif.rsp_valid), 32'd0);
    check("rst_gid",   32'(bif.grant_id), 32'd0);
    check("rst_res",   32'(bif.rsp_result), 32'd0);
    check("rst_err",   32'(bif.rsp_err), 32'd0);
    check("rst_opnds", 32'({bif.alu_op, bif.alu_a, bif.alu_b}), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    last    = N - 1;

    // round robin with everyone requesting: 0,1,2,3,0
    lat_force = 1;
    for (int k = 0; k < N; k++) set_req(k, 3'd1, 8'($urandom), 8'($urandom));
    drive();
    from_idle = 1'b1;
    for (int j = 0; j < 5; j++) begin
      w = j % N;
      expect_rsp("rr", w, exp_rsp(rop[w], ra[w], rb[w]), issue_of(w) + (from_idle ? 1 : 2), issue_of(w));
      last = w;
      if (j == 4) pend = '0;
      else set_req(w, 3'd1, 8'($urandom), 8'($urandom));
      drive();
      from_idle = 1'b0;
    end
    repeat (2) @(negedge clk);

    // single add, done after one cycle
    set_req(0, 3'd1, 8'h12, 8'h34);
    drive();
    expect_rsp("add", 0, 17'h00046, 2, 1);
    check("add_const", 32'(bif.rsp_result), 32'h0046);
    last = 0;
    pend = '0;
    drive();
    @(negedge clk);
    check("add_hold_res", 32'(bif.rsp_result), 32'h0046);
    check("add_valid_lo", 32'(bif.rsp_valid), 32'd0);
    check("add_idle",     32'(bif.busy), 32'd0);
    check("add_gap1",     32'(bif.alu_start), 32'd0);
    @(negedge clk);
    check("add_gap2",     32'(bif.alu_start), 32'd0);

    // mul FF*FF, done after three cycles
    lat_force = 3;
    set_req(2, 3'd4, 8'hFF, 8'hFF);
    drive();
    expect_rsp("mul", 2, {1'b0, 16'hFE01}, 4, 3);
    last = 2;
    pend = '0;
    drive();
    @(negedge clk);

    // no_op: one start cycle, zero result
    set_req(1, 3'd0, 8'($urandom), 8'($urandom));
    drive();
    expect_rsp("noop", 1, 17'd0, 2, 1);
    last = 1;
    pend = '0;
    drive();
    @(negedge clk);

    // illegal opcode: ALU untouched, error response
    set_req(3, 3'b110, 8'($urandom), 8'($urandom));
    drive();
    expect_rsp("illegal", 3, {1'b1, 16'h0000}, 1, 0);
    last = 3;
    pend = '0;
    drive();
    @(negedge clk);

    // reset in the middle of a long mul
    lat_force = 10;
    set_req(2, 3'd4, 8'($urandom), 8'($urandom));
    drive();
    repeat (3) @(negedge clk);
    check("mid_inissue", 32'(bif.alu_start), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_start", 32'(bif.alu_start), 32'd0);
    check("mid_busy",  32'(bif.busy), 32'd0);
    check("mid_valid", 32'(bif.rsp_valid), 32'd0);
    pend = '0;
    set_req(1, 3'd1, 8'($urandom), 8'($urandom));
    set_req(3, 3'd1, 8'($urandom), 8'($urandom));
    drive();
    repeat (2) @(negedge clk);
    lat_force = 1;
    reset_n   = 1'b1;
    last      = N - 1;
    expect_rsp("rst_win", 1, exp_rsp(rop[1], ra[1], rb[1]), 2, 1);
    lat_force = 0;
    last      = 1;
    pend[1]   = 1'b0;
    drive();
    from_idle = 1'b0;

    // random traffic against the round-robin reference model
    for (int t = 0; t < 150; t++) begin
      if (pend == '0) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        do p = N'($urandom); while (p == '0);
        for (int k = 0; k < N; k++) if (p[k]) rand_req(k);
        drive();
        from_idle = 1'b1;
      end
      w = rr_pick(pend, last);
      expect_rsp("rand", w, exp_rsp(rop[w], ra[w], rb[w]), issue_of(w) + (from_idle ? 1 : 2), issue_of(w));
      last    = w;
      pend[w] = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) rand_req(k);
      end
      drive();
      from_idle = 1'b0;
    end
    pend = '0;
    drive();
    repeat (2) @(negedge clk);

`ifdef TINYALU_ARB_TIMEOUT_EN
    // watchdog: done never comes
    lat_force = 100;
    set_req(0, 3'd1, 8'($urandom), 8'($urandom));
    drive();
    expect_rsp("tmo", 0, {1'b1, 16'hFFFF}, 17, 16);
    pend = '0;
    drive();
    @(negedge clk);
    check("tmo_idle", 32'(bif.busy), 32'd0);
    lat_force = 0;
`endif

    check("start_gap", gap_viol, 32'd0);
    check("onehot",    multi_hot, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
